// File: rtl/mc_datapath.sv
// Multi-cycle MIPS-subset datapath: FETCH/DECODE/EXEC/MEM/WB controller with
// A, B, ALUOut and MDR staging registers and a 32-entry register file.
module mc_datapath #(
    parameter int DATA_W   = 32,
    parameter int IMEM_AW  = 8,
    parameter int DMEM_AW  = 8,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_data,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    output logic               dmem_we,
    output logic               dmem_re,
    input  logic [DATA_W-1:0]  dmem_rdata,
    input  logic               dmem_ready,
    output logic [IMEM_AW-1:0] pc,
    output logic               instr_done,
    output logic               illegal
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_NOR = 6'h27;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    state_t             r_state;
    logic [IMEM_AW-1:0] r_pc;
    logic [31:0]        r_ir;
    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  r_b;
    logic [DATA_W-1:0]  r_alu_out;
    logic [DATA_W-1:0]  r_mdr;

    // Instruction fields, always taken from the latched IR.
    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;
    logic [25:0] w_target;

    assign w_op     = r_ir[31:26];
    assign w_rs     = r_ir[25:21];
    assign w_rt     = r_ir[20:16];
    assign w_rd     = r_ir[15:11];
    assign w_funct  = r_ir[5:0];
    assign w_imm    = r_ir[15:0];
    assign w_target = r_ir[25:0];

    logic [DATA_W-1:0]  w_sext_imm;
    logic [IMEM_AW-1:0] w_pc_plus4;
    logic [IMEM_AW-1:0] w_br_target;
    logic [IMEM_AW-1:0] w_jump_pc;

    assign w_sext_imm = {{(DATA_W-16){w_imm[15]}}, w_imm};
    assign w_pc_plus4 = r_pc + IMEM_AW'(4);
    // During EXEC the PC already points past the branch, so the offset is
    // applied relative to branch address + 4 as in MIPS.
    assign w_br_target = r_pc + IMEM_AW'({{14{w_imm[15]}}, w_imm, 2'b00});
    // Jump keeps PC bits above 27 (only present for very wide PCs); the
    // truncating cast drops whatever does not fit in the PC.
    assign w_jump_pc = IMEM_AW'({32'(r_pc) >> 28, w_target, 2'b00});

    // Register file: r0 is hard-wired to zero, r1..r31 are resettable flops.
    logic [DATA_W-1:0] w_rf [32];
    logic              w_rf_we;
    logic [4:0]        w_wb_addr;
    logic [DATA_W-1:0] w_wb_data;

    assign w_rf_we   = (r_state == S_WB);
    assign w_wb_addr = (w_op == OP_RTYPE) ? w_rd : w_rt;
    assign w_wb_data = (w_op == OP_LW) ? r_mdr : r_alu_out;
    assign w_rf[0]   = '0;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_rf
            logic [DATA_W-1:0] r_q;
            // Write-back port for this entry; cleared by reset.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_q <= '0;
                end else if (w_rf_we && (w_wb_addr == 5'(gi))) begin
                    r_q <= w_wb_data;
                end
            end
            assign w_rf[gi] = r_q;
        end
    endgenerate

    // Opcode legality check used in DECODE.
    logic w_op_legal;
    always_comb begin
        w_op_legal = 1'b0;
        case (w_op)
            OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: w_op_legal = 1'b1;
            default:                                       w_op_legal = 1'b0;
        endcase
    end

    // ALU: R-type by funct, everything else is A + sext(imm16).
    logic [DATA_W-1:0] w_alu_result;
    logic              w_funct_ok;
    always_comb begin
        w_alu_result = '0;
        w_funct_ok   = 1'b0;
        if (w_op == OP_RTYPE) begin
            w_funct_ok = 1'b1;
            case (w_funct)
                FN_ADD:  w_alu_result = r_a + r_b;
                FN_SUB:  w_alu_result = r_a - r_b;
                FN_AND:  w_alu_result = r_a & r_b;
                FN_OR:   w_alu_result = r_a | r_b;
                FN_NOR:  w_alu_result = ~(r_a | r_b);
                FN_SLT:  w_alu_result = {{(DATA_W-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
                default: w_funct_ok   = 1'b0;
            endcase
        end else begin
            w_alu_result = r_a + w_sext_imm;
        end
    end

    // Main controller: state sequencing and datapath register updates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_pc      <= IMEM_AW'(RESET_PC);
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_alu_out <= '0;
            r_mdr     <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_ir    <= imem_data;
                    r_pc    <= w_pc_plus4;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    if (!w_op_legal) begin
                        r_state <= S_FETCH;
                    end else begin
                        r_a <= w_rf[w_rs];
                        r_b <= w_rf[w_rt];
                        if (w_op == OP_J) begin
                            r_pc    <= w_jump_pc;
                            r_state <= S_FETCH;
                        end else begin
                            r_state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    case (w_op)
                        OP_RTYPE: begin
                            if (w_funct_ok) begin
                                r_alu_out <= w_alu_result;
                                r_state   <= S_WB;
                            end else begin
                                r_state <= S_FETCH;
                            end
                        end
                        OP_ADDI: begin
                            r_alu_out <= w_alu_result;
                            r_state   <= S_WB;
                        end
                        OP_LW, OP_SW: begin
                            r_alu_out <= w_alu_result;
                            r_state   <= S_MEM;
                        end
                        OP_BEQ: begin
                            if (r_a == r_b) begin
                                r_pc <= w_br_target;
                            end
                            r_state <= S_FETCH;
                        end
                        default: r_state <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (w_op == OP_LW) begin
                            r_mdr   <= dmem_rdata;
                            r_state <= S_WB;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_WB:    r_state <= S_FETCH;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Memory strobes are gated by reset so an aborted access never completes.
    assign dmem_re    = rst_n && (r_state == S_MEM) && (w_op == OP_LW);
    assign dmem_we    = rst_n && (r_state == S_MEM) && (w_op == OP_SW);
    assign dmem_addr  = r_alu_out[DMEM_AW-1:0];
    assign dmem_wdata = r_b;
    assign imem_addr  = r_pc;
    assign pc         = r_pc;

    assign illegal = ((r_state == S_DECODE) && !w_op_legal) ||
                     ((r_state == S_EXEC) && (w_op == OP_RTYPE) && !w_funct_ok);

    assign instr_done = illegal ||
                        ((r_state == S_DECODE) && (w_op == OP_J)) ||
                        ((r_state == S_EXEC) && (w_op == OP_BEQ)) ||
                        ((r_state == S_MEM) && (w_op == OP_SW) && dmem_ready) ||
                        (r_state == S_WB);

endmodule

// File: tb/tb_mc_datapath.sv
// Bench for mc_datapath: small programs in a behavioural instruction/data
// memory, store scoreboard, retirement-cycle and PC checks.
module tb_mc_datapath;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic [7:0]  dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_we;
    logic        dmem_re;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic [7:0]  pc;
    logic        instr_done;
    logic        illegal;

    mc_datapath dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_we    (dmem_we),
        .dmem_re    (dmem_re),
        .dmem_rdata (dmem_rdata),
        .dmem_ready (dmem_ready),
        .pc         (pc),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] imem      [64];
    logic [31:0] dmem      [64];
    logic [31:0] dmem_init [64];
    logic        dmem_wr   [64];
    int          wait_cfg = 0;
    int          mem_cnt  = 0;
    int          cyc      = 0;
    int          we_cycles = 0;
    int          store_count = 0;

    int          done_q [$];
    int          ill_q  [$];
    logic [39:0] exp_q  [$];

    assign imem_data  = imem[imem_addr[7:2]];
    assign dmem_rdata = dmem_wr[dmem_addr[7:2]] ? dmem[dmem_addr[7:2]] : dmem_init[dmem_addr[7:2]];
    assign dmem_ready = (dmem_we || dmem_re) && (mem_cnt >= wait_cfg);

    // Data memory model with programmable wait states.
    always @(posedge clk) begin
        if (!rst_n) begin
            mem_cnt <= 0;
            for (int i = 0; i < 64; i++) dmem_wr[i] <= 1'b0;
        end else begin
            if ((dmem_we || dmem_re) && !dmem_ready) mem_cnt <= mem_cnt + 1;
            else mem_cnt <= 0;
            if (dmem_we && dmem_ready) begin
                dmem[dmem_addr[7:2]]    <= dmem_wdata;
                dmem_wr[dmem_addr[7:2]] <= 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else cyc <= cyc + 1;
    end

    // Monitor: retirement/illegal cycle log and store scoreboard.
    always @(negedge clk) begin
        if (rst_n && instr_done) done_q.push_back(cyc + 1);
        if (rst_n && illegal) ill_q.push_back(cyc + 1);
        if (dmem_we) we_cycles++;
        if (dmem_we && dmem_ready) begin
            logic [39:0] e;
            store_count++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL store_unexpected: got addr=%0h data=%0h, required none", dmem_addr, dmem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({dmem_addr, dmem_wdata} !== e) begin
                    bad++;
                    $display("FAIL store: got addr=%0h data=%0h, required addr=%0h data=%0h",
                             dmem_addr, dmem_wdata, e[39:32], e[31:0]);
                end else begin
                    $display("store addr=%0h data=%0h ok", dmem_addr, dmem_wdata);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input int target);
        return {6'h02, 26'(target)};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) begin
            imem[i]      = 32'h0;
            dmem[i]      = 32'h0;
            dmem_init[i] = 32'h0;
        end
    endtask

    // Hold reset, set the wait-state count, clear logs, then release.
    task automatic start_prog(input int wcfg);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        done_q.delete();
        ill_q.delete();
        exp_q.delete();
        we_cycles   = 0;
        store_count = 0;
        wait_cfg    = wcfg;
        rst_n       = 1'b1;
    endtask

    // Step clocks until n instructions have retired or the budget runs out.
    task automatic run_until(input int n, input int budget);
        int k = 0;
        while (done_q.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        total++;
        if (done_q.size() < n) begin
            bad++;
            $display("FAIL timeout: retired=%0d, required=%0d", done_q.size(), n);
        end
    endtask

    task automatic test_reset();
        clear_mem();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total += 6;
        if (pc !== 8'h00) begin bad++; $display("FAIL reset_pc: got %0h, required 0", pc); end
        if (imem_addr !== 8'h00) begin bad++; $display("FAIL reset_imem_addr: got %0h, required 0", imem_addr); end
        if (dmem_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b, required 0", dmem_we); end
        if (dmem_re !== 1'b0) begin bad++; $display("FAIL reset_re: got %b, required 0", dmem_re); end
        if (instr_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b, required 0", instr_done); end
        if (illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal: got %b, required 0", illegal); end
        $display("test_reset checked pc=%0h", pc);
    endtask

    task automatic test_add_mem();
        clear_mem();
        imem[0] = enc_i(6'h08, 0, 1, 5);
        imem[1] = enc_r(1, 1, 2, 6'h20);
        imem[2] = enc_i(6'h2B, 0, 2, 4);
        imem[3] = enc_i(6'h23, 0, 3, 4);
        imem[4] = enc_i(6'h2B, 0, 3, 8);
        imem[5] = enc_j(5);
        start_prog(3);
        exp_q.push_back({8'h04, 32'd10});
        exp_q.push_back({8'h08, 32'd10});
        run_until(3, 200);
        total++;
        if (we_cycles != 4) begin bad++; $display("FAIL sw_we_cycles: got %0d, required 4", we_cycles); end
        run_until(5, 200);
        total += 5;
        if (done_q[0] != 4) begin bad++; $display("FAIL addi_done: got %0d, required 4", done_q[0]); end
        if (done_q[1] != 8) begin bad++; $display("FAIL add_done: got %0d, required 8", done_q[1]); end
        if (done_q[2] != 15) begin bad++; $display("FAIL sw_done: got %0d, required 15", done_q[2]); end
        if (done_q[3] != 23) begin bad++; $display("FAIL lw_done: got %0d, required 23", done_q[3]); end
        if (done_q[4] != 30) begin bad++; $display("FAIL sw2_done: got %0d, required 30", done_q[4]); end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL add_mem_pending: got %0d left, required 0", exp_q.size()); end
        $display("test_add_mem retired=%0d", done_q.size());
    endtask

    task automatic test_alu_corners();
        clear_mem();
        dmem_init[4] = 32'h7FFF_FFFF;
        imem[0]  = enc_i(6'h08, 0, 0, 7);
        imem[1]  = enc_i(6'h2B, 0, 0, 32'h20);
        imem[2]  = enc_i(6'h08, 0, 4, -1);
        imem[3]  = enc_i(6'h08, 0, 5, 1);
        imem[4]  = enc_r(4, 5, 6, 6'h2A);
        imem[5]  = enc_i(6'h2B, 0, 6, 32'h24);
        imem[6]  = enc_i(6'h23, 0, 7, 32'h10);
        imem[7]  = enc_r(7, 5, 8, 6'h20);
        imem[8]  = enc_i(6'h2B, 0, 8, 32'h28);
        imem[9]  = enc_r(5, 4, 9, 6'h2A);
        imem[10] = enc_i(6'h2B, 0, 9, 32'h2C);
        imem[11] = enc_r(5, 4, 10, 6'h22);
        imem[12] = enc_i(6'h2B, 0, 10, 32'h30);
        imem[13] = enc_r(7, 4, 11, 6'h24);
        imem[14] = enc_i(6'h2B, 0, 11, 32'h34);
        imem[15] = enc_r(7, 0, 12, 6'h27);
        imem[16] = enc_i(6'h2B, 0, 12, 32'h38);
        imem[17] = enc_r(5, 10, 13, 6'h25);
        imem[18] = enc_i(6'h2B, 0, 13, 32'h3C);
        imem[19] = enc_i(6'h08, 4, 14, -2);
        imem[20] = enc_i(6'h2B, 0, 14, 32'h40);
        imem[21] = enc_j(21);
        start_prog(0);
        exp_q.push_back({8'h20, 32'h0000_0000});
        exp_q.push_back({8'h24, 32'h0000_0001});
        exp_q.push_back({8'h28, 32'h8000_0000});
        exp_q.push_back({8'h2C, 32'h0000_0000});
        exp_q.push_back({8'h30, 32'h0000_0002});
        exp_q.push_back({8'h34, 32'h7FFF_FFFF});
        exp_q.push_back({8'h38, 32'h8000_0000});
        exp_q.push_back({8'h3C, 32'h0000_0003});
        exp_q.push_back({8'h40, 32'hFFFF_FFFD});
        run_until(21, 3000);
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL alu_pending: got %0d left, required 0", exp_q.size()); end
        $display("test_alu_corners retired=%0d", done_q.size());
    endtask

    task automatic test_branch_jump();
        clear_mem();
        imem[0] = enc_i(6'h08, 0, 1, 5);
        imem[1] = enc_i(6'h08, 0, 2, 6);
        imem[2] = enc_i(6'h04, 1, 2, 100);
        imem[3] = enc_i(6'h04, 1, 1, -1);
        start_prog(0);
        run_until(3, 100);
        total += 2;
        if (pc !== 8'd12) begin bad++; $display("FAIL beq_not_taken_pc: got %0d, required 12", pc); end
        if (done_q[2] != 11) begin bad++; $display("FAIL beq_nt_done: got %0d, required 11", done_q[2]); end
        run_until(4, 100);
        total += 2;
        if (pc !== 8'd12) begin bad++; $display("FAIL beq_taken_pc: got %0d, required 12", pc); end
        if (done_q[3] != 14) begin bad++; $display("FAIL beq_t_done: got %0d, required 14", done_q[3]); end
        run_until(5, 100);
        total++;
        if (pc !== 8'd12) begin bad++; $display("FAIL beq_loop_pc: got %0d, required 12", pc); end

        clear_mem();
        imem[0]  = enc_j(8);
        imem[8]  = enc_i(6'h08, 0, 1, 3);
        imem[9]  = enc_i(6'h2B, 0, 1, 0);
        imem[10] = enc_j(32'h4B);
        imem[11] = enc_i(6'h2B, 0, 1, 4);
        imem[12] = enc_j(12);
        start_prog(0);
        exp_q.push_back({8'h00, 32'd3});
        exp_q.push_back({8'h04, 32'd3});
        run_until(1, 50);
        total += 2;
        if (pc !== 8'd32) begin bad++; $display("FAIL j_pc: got %0d, required 32", pc); end
        if (done_q[0] != 2) begin bad++; $display("FAIL j_done: got %0d, required 2", done_q[0]); end
        run_until(4, 100);
        total++;
        if (pc !== 8'h2C) begin bad++; $display("FAIL j_trunc_pc: got %0h, required 2c", pc); end
        run_until(6, 100);
        total += 2;
        if (pc !== 8'd48) begin bad++; $display("FAIL j_self_pc: got %0d, required 48", pc); end
        if (exp_q.size() != 0) begin bad++; $display("FAIL jump_pending: got %0d left, required 0", exp_q.size()); end
        $display("test_branch_jump pc=%0d", pc);
    endtask

    task automatic test_illegal();
        clear_mem();
        imem[0] = enc_i(6'h08, 0, 1, 5);
        imem[1] = enc_i(6'h3F, 0, 1, 1);
        imem[2] = enc_r(1, 1, 1, 6'h3F);
        imem[3] = enc_i(6'h2B, 0, 1, 0);
        imem[4] = enc_j(4);
        start_prog(0);
        exp_q.push_back({8'h00, 32'd5});
        run_until(2, 50);
        total++;
        if (pc !== 8'd8) begin bad++; $display("FAIL ill_op_pc: got %0d, required 8", pc); end
        run_until(3, 50);
        total += 5;
        if (pc !== 8'd12) begin bad++; $display("FAIL ill_fn_pc: got %0d, required 12", pc); end
        if (done_q[1] != 6) begin bad++; $display("FAIL ill_op_done: got %0d, required 6", done_q[1]); end
        if (done_q[2] != 9) begin bad++; $display("FAIL ill_fn_done: got %0d, required 9", done_q[2]); end
        if (ill_q.size() != 2) begin bad++; $display("FAIL ill_count: got %0d, required 2", ill_q.size()); end
        if (ill_q[0] != 6 || ill_q[1] != 9) begin
            bad++;
            $display("FAIL ill_cycles: got %0d,%0d, required 6,9", ill_q[0], ill_q[1]);
        end
        run_until(5, 50);
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL ill_pending: got %0d left, required 0", exp_q.size()); end
        $display("test_illegal pulses=%0d", ill_q.size());
    endtask

    task automatic test_reset_mid_mem();
        int k = 0;
        clear_mem();
        imem[0] = enc_i(6'h08, 0, 1, 9);
        imem[1] = enc_i(6'h2B, 0, 1, 0);
        start_prog(1000);
        run_until(1, 50);
        while (!dmem_we && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        total++;
        if (dmem_we !== 1'b1) begin bad++; $display("FAIL mid_mem_reach: got we=%b, required 1", dmem_we); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        total += 2;
        if (pc !== 8'h00) begin bad++; $display("FAIL mid_mem_pc: got %0h, required 0", pc); end
        if (dmem_we !== 1'b0) begin bad++; $display("FAIL mid_mem_we: got %b, required 0", dmem_we); end
        imem[0] = enc_j(0);
        imem[1] = enc_j(0);
        wait_cfg = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        total++;
        if (store_count != 0) begin bad++; $display("FAIL mid_mem_store: got %0d stores, required 0", store_count); end
        $display("test_reset_mid_mem stores=%0d", store_count);
    endtask

    initial begin
        test_reset();
        test_add_mem();
        test_alu_corners();
        test_branch_jump();
        test_illegal();
        test_reset_mid_mem();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
